mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_cpu_pkg.sv | 51 +++++
 rtl/lsu.sv | 117 +++++++++++
 rtl/mem_stage.sv | 67 ++++++
 tb/tb_mem_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared types for the memory stage: pipeline structs, LSU state encoding
// and access-size codes.
package riscv_cpu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [1:0] LSU_BYTE = 2'b00;
    localparam logic [1:0] LSU_HALF = 2'b01;
    localparam logic [1:0] LSU_WORD = 2'b10;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       mem_unsigned;
    } mem_ctl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctl_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] mem_wdata;
        logic [4:0]            dest_reg;
        logic [DATA_WIDTH-1:0] alu_result;
    } ex2mem_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] mem_rdata;
        logic [4:0]            dest_reg;
    } mem2wb_t;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'b00,
        LSU_WAIT_GNT    = 2'b01,
        LSU_WAIT_RVALID = 2'b10
    } lsu_state_t;

    // Any size code other than byte/half is handled as a full word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        if (size == LSU_BYTE) return 1'b0;
        if (size == LSU_HALF) return addr_lo[0];
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/lsu.sv
// Load/store unit: request FSM, store lane formatting and load extraction.
// Bus handshake: a request is accepted on the cycle data_req_o and data_gnt_i
// are both high; read data is valid on the single cycle data_rvalid_i is high.
module lsu
    import riscv_cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  mem_ctl_t              mem_ctl_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  stall_o,
    output logic                  fault_o,
    output logic                  misaligned_o,
    output logic                  load_done_o,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output lsu_state_t            state_o
);

    lsu_state_t            state_q;
    logic                  is_load;
    logic                  is_store;
    logic                  aligned;
    logic [DATA_WIDTH-1:0] byte_sh;
    logic [DATA_WIDTH-1:0] half_sh;

    // A read+write combination is treated as a read.
    assign is_load  = mem_ctl_i.mem_read;
    assign is_store = mem_ctl_i.mem_write & ~mem_ctl_i.mem_read;
    assign fault_o  = (is_load | is_store) & is_misaligned(mem_ctl_i.mem_size, addr_i[1:0]);
    assign aligned  = (is_load | is_store) & ~fault_o;

    assign state_o      = state_q;
    assign data_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign data_we_o    = data_req_o & is_store;
    assign load_done_o  = ~rst_i & (state_q == LSU_WAIT_RVALID) & data_rvalid_i;

    always_comb begin
        data_req_o = 1'b0;
        stall_o    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                LSU_IDLE: begin
                    data_req_o = aligned;
                    stall_o    = aligned & ~(is_store & data_gnt_i);
                end
                LSU_WAIT_GNT: begin
                    data_req_o = 1'b1;
                    stall_o    = ~(is_store & data_gnt_i);
                end
                LSU_WAIT_RVALID: stall_o = ~data_rvalid_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        data_be_o    = 4'b1111;
        data_wdata_o = wdata_i;
        case (mem_ctl_i.mem_size)
            LSU_BYTE: begin
                data_be_o    = 4'b0001 << addr_i[1:0];
                data_wdata_o = {4{wdata_i[7:0]}};
            end
            LSU_HALF: begin
                data_be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                data_wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sh = data_rdata_i >> {addr_i[1:0], 3'b000};
    assign half_sh = data_rdata_i >> {addr_i[1], 4'b0000};

    always_comb begin
        load_data_o = data_rdata_i;
        case (mem_ctl_i.mem_size)
            LSU_BYTE: load_data_o = {{24{~mem_ctl_i.mem_unsigned & byte_sh[7]}}, byte_sh[7:0]};
            LSU_HALF: load_data_o = {{16{~mem_ctl_i.mem_unsigned & half_sh[15]}}, half_sh[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LSU_IDLE;
            misaligned_o <= 1'b0;
        end else begin
            misaligned_o <= (state_q == LSU_IDLE) & fault_o;
            case (state_q)
                LSU_IDLE: begin
                    if (aligned) begin
                        if (!data_gnt_i)    state_q <= LSU_WAIT_GNT;
                        else if (is_load)   state_q <= LSU_WAIT_RVALID;
                    end
                end
                LSU_WAIT_GNT: begin
                    if (data_gnt_i) state_q <= is_load ? LSU_WAIT_RVALID : LSU_IDLE;
                end
                LSU_WAIT_RVALID: begin
                    if (data_rvalid_i) state_q <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data bus through the LSU and registers
// results into the writeback stage, inserting bubbles while stalled.
module mem_stage
    import riscv_cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  mem_ctl_t              mem_ctl_i,
    input  wb_ctl_t               wb_ctl_i,
    input  ex2mem_t               mem_pipeline_i,
    output wb_ctl_t               wb_ctl_o,
    output mem2wb_t               wb_pipeline_o,
    output logic                  stall_o,
    output logic                  misaligned_o,
    output logic                  data_req_o,
    output logic                  data_we_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic [3:0]            data_be_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output lsu_state_t            lsu_state_o
);

    logic                  fault;
    logic                  load_done;
    logic [DATA_WIDTH-1:0] load_data;

    lsu u_lsu (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_ctl_i     (mem_ctl_i),
        .addr_i        (mem_pipeline_i.alu_result),
        .wdata_i       (mem_pipeline_i.mem_wdata),
        .data_req_o    (data_req_o),
        .data_we_o     (data_we_o),
        .data_addr_o   (data_addr_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .stall_o       (stall_o),
        .fault_o       (fault),
        .misaligned_o  (misaligned_o),
        .load_done_o   (load_done),
        .load_data_o   (load_data),
        .state_o       (lsu_state_o)
    );

    // A stalled cycle or a faulting access writes a bubble so each
    // instruction reaches writeback exactly once.
    always_ff @(posedge clk_i) begin
        if (rst_i || stall_o || fault) begin
            wb_ctl_o      <= '0;
            wb_pipeline_o <= '0;
        end else begin
            wb_ctl_o                 <= wb_ctl_i;
            wb_pipeline_o.pc         <= mem_pipeline_i.pc;
            wb_pipeline_o.alu_result <= mem_pipeline_i.alu_result;
            wb_pipeline_o.dest_reg   <= mem_pipeline_i.dest_reg;
            wb_pipeline_o.mem_rdata  <= load_done ? load_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized accesses,
// each checked against a behavioural model of the stage.
module tb_mem_stage;
    import riscv_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mem_ctl_t    mem_ctl;
    wb_ctl_t     wb_ctl;
    ex2mem_t     ex;
    wb_ctl_t     wb_ctl_o;
    mem2wb_t     wb_pipe_o;
    logic        stall, misaligned, data_req, data_we;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        data_gnt, data_rvalid;
    lsu_state_t  lsu_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    int          op_stall_cnt, op_wb_cnt;
    logic        op_req_seen;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_rdata;

    // clock / reset block
    always #5 clk = ~clk;

    mem_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mem_ctl_i      (mem_ctl),
        .wb_ctl_i       (wb_ctl),
        .mem_pipeline_i (ex),
        .wb_ctl_o       (wb_ctl_o),
        .wb_pipeline_o  (wb_pipe_o),
        .stall_o        (stall),
        .misaligned_o   (misaligned),
        .data_req_o     (data_req),
        .data_we_o      (data_we),
        .data_addr_o    (data_addr),
        .data_be_o      (data_be),
        .data_wdata_o   (data_wdata),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata),
        .lsu_state_o    (lsu_state)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model, written from the access rules with plain arithmetic
    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << (2 * (lane / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return (w % 256) * 32'h0101_0101;
        if (size == 2'd1) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int lane;
        lane = int'(addr % 4);
        if (size == 2'd0) begin
            v = (rd / (32'd1 << (8 * lane))) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rd / (32'd1 << (16 * (lane / 2)))) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic drive_nop();
        mem_ctl     = '0;
        wb_ctl      = '0;
        ex          = '0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
    endtask

    // driver: one instruction, cycle by cycle, until it leaves the stage
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                          input int g, input int r, input logic [1:0] wbc, input logic spur);
        logic        is_ld, is_st, mis, al, exp_req, exp_stall;
        logic [31:0] exp_rdata, pc;
        logic [4:0]  dest;
        int          last;
        is_ld = rd;
        is_st = wr && !rd;
        mis   = (is_ld || is_st) && model_misaligned(size, addr);
        al    = (is_ld || is_st) && !mis;
        last  = !al ? 0 : (is_st ? g : g + r);
        exp_rdata = (al && is_ld) ? model_load(size, uns, addr, rdata) : 32'h0;
        if (!mis) exp_q.push_back(exp_rdata);
        pc   = $urandom;
        dest = 5'($urandom_range(0, 31));
        mem_ctl = '{mem_read: rd, mem_write: wr, mem_size: size, mem_unsigned: uns};
        wb_ctl  = wbc;
        ex      = '{pc: pc, mem_wdata: wdata, dest_reg: dest, alu_result: addr};
        op_stall_cnt = 0;
        op_wb_cnt    = 0;
        op_req_seen  = 1'b0;
        for (int c = 0; c <= last; c++) begin
            data_gnt    = al && (c == g);
            data_rvalid = (al && is_ld && c == last) || (spur && c <= g);
            data_rdata  = (al && is_ld && c == last) ? rdata : $urandom;
            #4;
            exp_req   = al && (c <= g);
            exp_stall = al && (c != last);
            check("req", data_req, exp_req);
            check("stall", stall, exp_stall);
            if (data_req) begin
                op_req_seen = 1'b1;
                obs_be      = data_be;
                obs_wdata   = data_wdata;
            end
            if (exp_req) begin
                check("addr", data_addr, addr & 32'hFFFF_FFFC);
                check("be", data_be, model_be(size, addr));
                check("we", data_we, is_st);
                if (is_st) check("wdata", data_wdata, model_wdata(size, wdata));
            end
            if (stall) op_stall_cnt++;
            @(posedge clk);
            #1;
            if (wb_ctl_o != 2'b00) op_wb_cnt++;
            if (c < last || mis) begin
                check("wb_ctl_bubble", wb_ctl_o, 2'b00);
                check("wb_pipe_bubble", wb_pipe_o, '0);
                check("misaligned", misaligned, mis);
            end else begin
                check("misaligned", misaligned, 1'b0);
                check("wb_ctl", wb_ctl_o, wbc);
                check("wb_pc", wb_pipe_o.pc, pc);
                check("wb_alu", wb_pipe_o.alu_result, addr);
                check("wb_dest", wb_pipe_o.dest_reg, dest);
                obs_rdata = wb_pipe_o.mem_rdata;
                if (exp_q.size() == 0) check("scoreboard_empty", 1'b1, 1'b0);
                else check("wb_rdata", wb_pipe_o.mem_rdata, exp_q.pop_front());
            end
        end
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
    endtask

    initial begin
        drive_nop();
        // reset with a live aligned load on the inputs
        mem_ctl = '{mem_read: 1'b1, mem_write: 1'b0, mem_size: LSU_WORD, mem_unsigned: 1'b0};
        wb_ctl  = 2'b11;
        ex      = '{pc: 32'h44, mem_wdata: 32'h0, dest_reg: 5'd3, alu_result: 32'h10};
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #4;
            check("rst_req", data_req, 1'b0);
            check("rst_stall", stall, 1'b0);
            @(posedge clk);
            #1;
        end
        check("rst_wb_ctl", wb_ctl_o, 2'b00);
        check("rst_wb_pipe", wb_pipe_o, '0);
        check("rst_misaligned", misaligned, 1'b0);
        check("rst_state", lsu_state, LSU_IDLE);
        rst = 1'b0;
        drive_nop();

        // sw 0x100, granted same cycle
        run_op(1'b0, 1'b1, LSU_WORD, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 1, 2'b01, 1'b0);
        check("sw_be", obs_be, 4'hF);
        check("sw_stall_cycles", op_stall_cnt, 0);

        // lb 0x103, gnt after 2 cycles, rvalid 3 cycles later
        run_op(1'b1, 1'b0, LSU_BYTE, 1'b0, 32'h103, 32'h0, 32'h80FF_FFFF, 2, 3, 2'b11, 1'b0);
        check("lb_rdata", obs_rdata, 32'hFFFF_FF80);
        check("lb_stall_cycles", op_stall_cnt, 5);
        check("lb_wb_entries", op_wb_cnt, 1);

        // lhu 0x202
        run_op(1'b1, 1'b0, LSU_HALF, 1'b1, 32'h202, 32'h0, 32'hABCD_1234, 1, 1, 2'b11, 1'b0);
        check("lhu_be", obs_be, 4'hC);
        check("lhu_rdata", obs_rdata, 32'h0000_ABCD);

        // sh 0x301 misaligned: no request, one-cycle pulse
        run_op(1'b0, 1'b1, LSU_HALF, 1'b0, 32'h301, 32'h1234, 32'h0, 0, 1, 2'b01, 1'b0);
        check("sh_mis_req", op_req_seen, 1'b0);
        run_op(1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 0, 1, 2'b01, 1'b0);

        // sb 0x002
        run_op(1'b0, 1'b1, LSU_BYTE, 1'b0, 32'h002, 32'h0000_00A5, 32'h0, 1, 1, 2'b01, 1'b0);
        check("sb_be", obs_be, 4'h4);
        check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

        // stray rvalid around a nop, a store and a read+write combination
        run_op(1'b0, 1'b0, LSU_WORD, 1'b0, 32'h8, 32'h0, 32'h0, 0, 1, 2'b10, 1'b1);
        run_op(1'b0, 1'b1, LSU_WORD, 1'b0, 32'h20, 32'h5555_AAAA, 32'h0, 2, 1, 2'b01, 1'b1);
        run_op(1'b1, 1'b1, LSU_HALF, 1'b0, 32'h42, 32'h0, 32'h8001_7FFF, 1, 2, 2'b11, 1'b1);

        // reset while waiting for rvalid, then a late rvalid
        mem_ctl = '{mem_read: 1'b1, mem_write: 1'b0, mem_size: LSU_WORD, mem_unsigned: 1'b0};
        wb_ctl  = 2'b11;
        ex      = '{pc: 32'h500, mem_wdata: 32'h0, dest_reg: 5'd7, alu_result: 32'h40};
        data_gnt = 1'b1;
        @(posedge clk);
        #1;
        check("rr_state_wait", lsu_state, LSU_WAIT_RVALID);
        data_gnt = 1'b0;
        rst = 1'b1;
        #4;
        check("rr_req", data_req, 1'b0);
        check("rr_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_nop();
        data_rvalid = 1'b1;
        data_rdata  = 32'h1234_5678;
        #4;
        check("rr_late_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        data_rvalid = 1'b0;
        check("rr_state_idle", lsu_state, LSU_IDLE);
        check("rr_wb_ctl", wb_ctl_o, 2'b00);
        check("rr_wb_pipe", wb_pipe_o, '0);

        // randomized accesses
        for (int n = 0; n < 60; n++) begin
            logic rd_b, wr_b;
            int   k;
            k    = $urandom_range(0, 3);
            rd_b = (k == 1) || (k == 3);
            wr_b = (k == 2) || (k == 3);
            run_op(rd_b, wr_b, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                   $urandom, $urandom_range(0, 3), $urandom_range(1, 3), 2'($urandom_range(1, 3)),
                   1'($urandom_range(0, 1)));
        end
        run_op(1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 0, 1, 2'b01, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
